// File: rtl/fnn_pkg.sv
// ---------------------------------------------------------------------------
// fnn_pkg : shared layer-sequencer state type and counter-width helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fnn_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  // Counter wide enough to hold the value n itself.
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnn_result_capture.sv
// ---------------------------------------------------------------------------
// fnn_result_capture : first-wins capture of per-neuron results under a mask
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fnn_result_capture #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              en,
  input  logic [NUM_NEURONS-1:0]            outvalid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0]             res [NUM_NEURONS],
  output logic                              all_done
);

  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  res_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  res_d [NUM_NEURONS];

  always_comb begin
    mask_d = mask_q;
    res_d  = res_q;
    if (clear) begin
      mask_d = '0;
      for (int i = 0; i < NUM_NEURONS; i++) res_d[i] = '0;
    end else if (en) begin
      // Once a neuron is masked, later pulses from it are ignored.
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (outvalid[i] && !mask_q[i]) begin
          mask_d[i] = 1'b1;
          res_d[i]  = data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) res_q[i] <= '0;
    end else begin
      mask_q <= mask_d;
      res_q  <= res_d;
    end
  end

  assign res      = res_q;
  assign all_done = &mask_q;

endmodule

`default_nettype wire

// File: rtl/fnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fnn_layer_sequencer : collect a vector, burst it to the neurons, gather and
//                       serialize their results.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fnn_layer_sequencer
  import fnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_MAX    = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             nrn_data,
  output logic                              nrn_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int WR_W      = CNT_W(NUM_INPUTS);
  localparam int DR_W      = CNT_W(NUM_NEURONS);
  localparam int WT_W      = CNT_W(WAIT_MAX);
  localparam int IN_IDX_W  = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int RES_IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic [WR_W-1:0] WR_LAST = WR_W'(NUM_INPUTS - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(NUM_NEURONS - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(WAIT_MAX - 1);

  seq_state_t            state_q, state_d;
  logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [WR_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [DR_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic [WT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] nrn_data_q, nrn_data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] in_buf_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] in_buf_d [NUM_INPUTS];

  logic                  cap_clear;
  logic                  cap_en;
  logic                  cap_done;
  logic [DATA_WIDTH-1:0] res [NUM_NEURONS];
  logic [WR_W-1:0]       rd_next;

  assign rd_next = rd_cnt_q + 1'b1;
  assign cap_en  = (state_q == WAIT);

  fnn_result_capture #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clear    (cap_clear),
    .en       (cap_en),
    .outvalid (nrn_outvalid),
    .data     (nrn_out),
    .res      (res),
    .all_done (cap_done)
  );

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    nrn_data_d  = nrn_data_q;
    err_d       = err_q;
    in_buf_d    = in_buf_q;
    cap_clear   = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          in_buf_d[wr_cnt_q[IN_IDX_W-1:0]] = in_data;
          if (wr_cnt_q == WR_LAST) begin
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            state_d    = STREAM;
            // Preload word 0 so the burst starts the very next cycle.
            nrn_data_d = (NUM_INPUTS == 1) ? in_data : in_buf_q[0];
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (rd_cnt_q == WR_LAST) begin
          state_d    = WAIT;
          rd_cnt_d   = '0;
          wait_cnt_d = '0;
          nrn_data_d = '0;
          cap_clear  = 1'b1;
        end else begin
          rd_cnt_d   = rd_next;
          nrn_data_d = in_buf_q[rd_next[IN_IDX_W-1:0]];
        end
      end
      WAIT: begin
        if (cap_done) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
          wait_cnt_d  = '0;
        end else if (wait_cnt_q == WT_LAST) begin
          err_d       = 1'b1;
          state_d     = DRAIN;
          drain_cnt_d = '0;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (drain_cnt_q == DR_LAST) begin
            state_d     = FILL;
            drain_cnt_d = '0;
            cap_clear   = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    in_buf_q <= in_buf_d;
    if (rst) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      nrn_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      nrn_data_q  <= nrn_data_d;
      err_q       <= err_d;
    end
  end

  // Handshake strobes decode straight from the state flop; res is frozen in DRAIN.
  assign in_ready    = (state_q == FILL);
  assign nrn_valid   = (state_q == STREAM);
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != FILL);
  assign nrn_data    = nrn_data_q;
  assign err_timeout = err_q;
  assign out_data    = out_valid ? res[drain_cnt_q[RES_IDX_W-1:0]] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fnn_layer_sequencer : randomized scenario bench with a neuron model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fnn_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int WM = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] nrn_data;
  logic          nrn_valid;
  logic [NN*DW-1:0] nrn_out;
  logic [NN-1:0] nrn_outvalid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] vec     [NI];
  logic [DW-1:0] exp_res [NN];
  bit            exp_err;

  always #5 clk = ~clk;

  fnn_layer_sequencer #(
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (DW),
    .WAIT_MAX    (WM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .nrn_data     (nrn_data),
    .nrn_valid    (nrn_valid),
    .nrn_out      (nrn_out),
    .nrn_outvalid (nrn_outvalid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  task automatic randomize_vec();
    for (int k = 0; k < NI; k++) vec[k] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    nrn_out      = '0;
    nrn_outvalid = '0;
    out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
  endtask

  // Present vec word by word; returns at the negedge after the last handshake.
  task automatic feed_vector(input bit gaps);
    int i = 0;
    int guard = 0;
    bit hs;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_in_ready: got %b expected 1", in_ready);
    end
    while (i < NI && guard < 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = vec[i];
      end
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (i != NI) begin
      errors++; $display("FAIL feed_accept: got %0d words expected %0d", i, NI);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || nrn_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_fill: got in_ready=%b busy=%b nrn_valid=%b expected 0 1 1",
               in_ready, busy, nrn_valid);
    end
  endtask

  task automatic collect_stream();
    logic [DW-1:0] got [$];
    int n = 0;
    while (nrn_valid === 1'b1 && n < NI + 4) begin
      got.push_back(nrn_data);
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != NI) begin
      errors++; $display("FAIL stream_len: got %0d cycles expected %0d", n, NI);
    end
    for (int k = 0; k < NI && k < got.size(); k++) begin
      checks++;
      if (got[k] !== vec[k]) begin
        errors++; $display("FAIL stream_word[%0d]: got %h expected %h", k, got[k], vec[k]);
      end
    end
  endtask

  // Neuron model: each live neuron pulses outvalid once after a random delay.
  task automatic respond(input bit [NN-1:0] silent, input bit dup3, input bit exp_to);
    int            d   [NN];
    logic [DW-1:0] val [NN];
    logic [DW-1:0] dupv;
    int            maxd = 0;
    int            exp_c;
    int            seen_c = -1;
    bit            is_dup;
    for (int k = 0; k < NN; k++) begin
      d[k]   = $urandom_range(0, 12);
      val[k] = DW'($urandom);
    end
    if (dup3) begin
      d[3] = 1;
      d[0] = 10;
    end
    for (int k = 0; k < NN; k++) if (!silent[k] && d[k] > maxd) maxd = d[k];
    dupv = ~val[3];
    for (int k = 0; k < NN; k++) exp_res[k] = silent[k] ? '0 : val[k];
    exp_c = exp_to ? WM : maxd + 2;
    for (int c = 0; c <= WM + 4; c++) begin
      if (out_valid === 1'b1) begin
        seen_c = c;
        break;
      end
      for (int k = 0; k < NN; k++) begin
        is_dup = dup3 && (k == 3) && (c == d[3] + 2);
        nrn_outvalid[k] = (!silent[k] && d[k] == c) || is_dup;
        nrn_out[k*DW +: DW] = is_dup ? dupv : (nrn_outvalid[k] ? val[k] : DW'($urandom));
      end
      @(negedge clk);
    end
    nrn_outvalid = '0;
    if (exp_to) exp_err = 1'b1;
    checks++;
    if (seen_c != exp_c) begin
      errors++; $display("FAIL wait_exit_cycle: got %0d expected %0d", seen_c, exp_c);
    end
    checks++;
    if (err_timeout !== exp_err) begin
      errors++; $display("FAIL err_timeout: got %b expected %b", err_timeout, exp_err);
    end
  endtask

  task automatic drain(input int stall_at, input bit hold_in);
    int            got = 0;
    int            cyc = 0;
    int            stall_left = 0;
    bit            stalled = 0;
    bit            prev_stall = 0;
    bit            rdy;
    logic [DW-1:0] prev_data = '0;
    if (hold_in) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
    end
    while (got < NN && cyc < 300) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_valid: got %b expected 1 at word %0d", out_valid, got);
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data) begin
          errors++; $display("FAIL drain_stable: got %h expected %h", out_data, prev_data);
        end
      end
      if (hold_in) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL drain_in_ready: got %b expected 0", in_ready);
        end
      end
      if (!stalled && got == stall_at) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        checks++;
        if (out_data !== exp_res[got]) begin
          errors++; $display("FAIL drain_word[%0d]: got %h expected %h", got, out_data, exp_res[got]);
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !rdy;
      prev_data  = out_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != NN) begin
      errors++; $display("FAIL drain_count: got %0d expected %0d", got, NN);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic run_vector(input bit gaps, input bit [NN-1:0] silent, input bit dup3,
                            input bit exp_to, input int stall_at, input bit hold_in);
    feed_vector(gaps);
    collect_stream();
    respond(silent, dup3, exp_to);
    drain(stall_at, hold_in);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || nrn_valid !== 1'b0 || nrn_data !== '0 || out_valid !== 1'b0 ||
        out_data !== '0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b nv=%b nd=%h ov=%b od=%h busy=%b err=%b expected 1 0 0 0 0 0 0",
               in_ready, nrn_valid, nrn_data, out_valid, out_data, busy, err_timeout);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_fill: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
  endtask

  task automatic test_stream_basic();
    for (int k = 0; k < NI; k++) vec[k] = DW'(k + 1);
    run_vector(1'b0, '0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_capture_dup();
    randomize_vec();
    run_vector(1'b1, '0, 1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_drain_stall();
    randomize_vec();
    run_vector(1'b0, '0, 1'b0, 1'b0, 4, 1'b0);
  endtask

  task automatic test_timeout();
    randomize_vec();
    run_vector(1'b0, NN'(1) << 7, 1'b0, 1'b1, -1, 1'b0);
    randomize_vec();
    run_vector(1'b1, '0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    randomize_vec();
    feed_vector(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (nrn_valid !== 1'b1 || nrn_data !== vec[2]) begin
      errors++; $display("FAIL stream_rd2: got valid=%b data=%h expected 1 %h", nrn_valid, nrn_data, vec[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    exp_err = 1'b0;
    checks++;
    if (nrn_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got nv=%b rdy=%b busy=%b err=%b expected 0 1 0 0",
               nrn_valid, in_ready, busy, err_timeout);
    end
    rst = 1'b0;
    randomize_vec();
    run_vector(1'b1, '0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    randomize_vec();
    run_vector(1'b0, '0, 1'b0, 1'b0, 2, 1'b1);
    randomize_vec();
    run_vector(1'b0, '0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      randomize_vec();
      run_vector(1'($urandom_range(0, 1)), '0, 1'b0, 1'b0, int'($urandom_range(0, NN)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_capture_dup();
    test_drain_stall();
    test_timeout();
    test_reset_mid_stream();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
